scc_param_syndrome_pipe: RTL and testbench

SCC_PARAM_SYNDROME_PIPE -- requirements
Module: scc_param_syndrome_pipe

---
 rtl/scc_pkg.sv | 39 +++
 rtl/scc_chunk_parity.sv | 29 ++
 rtl/scc_param_syndrome_pipe.sv | 144 ++++++++++++++
 tb/tb_scc_param_syndrome_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// ============================================================================
// Module      : scc_pkg
// Description : Shared constants for the syndrome pipe: default 8x72
//               parity-check matrix and the chunk-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package scc_pkg;

    localparam int         SCC_N       = 72;
    localparam int         SCC_R       = 8;
    localparam logic [7:0] SCC_GF_POLY = 8'h1D;

    // Column i of the matrix is alpha^i in GF(2^8) with x^8+x^4+x^3+x^2+1.
    function automatic logic [SCC_R-1:0][SCC_N-1:0] gen_8lc_h();
        logic [SCC_R-1:0][SCC_N-1:0] h;
        logic [7:0]                  a;
        h = '0;
        a = 8'h01;
        for (int i = 0; i < SCC_N; i++) begin
            for (int r = 0; r < SCC_R; r++) begin
                h[r][i] = a[r];
            end
            a = {a[6:0], 1'b0} ^ (a[7] ? SCC_GF_POLY : 8'h00);
        end
        return h;
    endfunction

    localparam logic [SCC_R-1:0][SCC_N-1:0] SCC_8LC_H = gen_8lc_h();

    function automatic int chunk_count(input int n, input int g);
        return (n + g - 1) / g;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scc_chunk_parity.sv
// ============================================================================
// Module      : scc_chunk_parity
// Description : Per-row partial parity of one G-bit codeword chunk.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module scc_chunk_parity
    import scc_pkg::*;
#(
    parameter int G = 8,
    parameter int R = SCC_R
) (
    input  logic [G-1:0]        chunk,
    input  logic [R-1:0][G-1:0] h_chunk,
    output logic [R-1:0]        parity
);

    always_comb begin
        parity = '0;
        for (int r = 0; r < R; r++) begin
            parity[r] = ^(chunk & h_chunk[r]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/scc_param_syndrome_pipe.sv
// ============================================================================
// Module      : scc_param_syndrome_pipe
// Description : Two-stage valid/ready syndrome checker with saturating
//               word and error counters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module scc_param_syndrome_pipe
    import scc_pkg::*;
#(
    parameter int                   N  = 72,
    parameter int                   R  = 8,
    parameter logic [R-1:0][N-1:0]  H  = SCC_8LC_H,
    parameter int                   G  = 8,
    parameter int                   CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_codeword,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_codeword,
    output logic [R-1:0]  out_syndrome,
    output logic          out_err,
    input  logic          cnt_clr,
    output logic [CW-1:0] word_cnt,
    output logic [CW-1:0] err_cnt
);

    localparam int            NC        = chunk_count(N, G);
    localparam int            NP        = NC * G;
    localparam logic [CW-1:0] C_CNT_MAX = '1;

    logic [NP-1:0]          w_cw_pad;
    logic [NC-1:0][R-1:0]   w_part;
    logic [R-1:0]           w_syn;
    logic                   w_s1_adv;
    logic                   w_s2_adv;
    logic                   w_hs;

    logic                   r_s1_valid;
    logic [N-1:0]           r_s1_cw;
    logic [NC-1:0][R-1:0]   r_s1_part;
    logic                   r_s2_valid;
    logic [N-1:0]           r_s2_cw;
    logic [R-1:0]           r_s2_syn;
    logic                   r_s2_err;
    logic [CW-1:0]          r_word_cnt;
    logic [CW-1:0]          r_err_cnt;

    // Zero-extension supplies the padding of a short final chunk.
    assign w_cw_pad = NP'(in_codeword);

    for (genvar c = 0; c < NC; c++) begin : g_chunk
        logic [R-1:0][G-1:0] w_hc;
        for (genvar r = 0; r < R; r++) begin : g_row
            for (genvar j = 0; j < G; j++) begin : g_bit
                if (c * G + j < N) begin : g_in
                    assign w_hc[r][j] = H[r][c * G + j];
                end else begin : g_pad
                    assign w_hc[r][j] = 1'b0;
                end
            end
        end
        scc_chunk_parity #(
            .G (G),
            .R (R)
        ) u_parity (
            .chunk   (w_cw_pad[c * G +: G]),
            .h_chunk (w_hc),
            .parity  (w_part[c])
        );
    end

    always_comb begin
        w_syn = '0;
        for (int c = 0; c < NC; c++) begin
            w_syn = w_syn ^ r_s1_part[c];
        end
    end

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_hs     = r_s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_part  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_cw   <= in_codeword;
                r_s1_part <= w_part;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_cw    <= '0;
            r_s2_syn   <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_cw  <= r_s1_cw;
                r_s2_syn <= w_syn;
                r_s2_err <= |w_syn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_hs) begin
            if (r_word_cnt != C_CNT_MAX) begin
                r_word_cnt <= r_word_cnt + CW'(1);
            end
            if (r_s2_err && (r_err_cnt != C_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CW'(1);
            end
        end
    end

    assign in_ready     = w_s1_adv;
    assign out_valid    = r_s2_valid;
    assign out_codeword = r_s2_cw;
    assign out_syndrome = r_s2_syn;
    assign out_err      = r_s2_err;
    assign word_cnt     = r_word_cnt;
    assign err_cnt      = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_scc_param_syndrome_pipe.sv
// ============================================================================
// Module      : tb_scc_param_syndrome_pipe
// Description : Self-checking bench: GF(2^8) reference model, scoreboard,
//               directed corner cases and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_scc_param_syndrome_pipe;

    localparam int N  = 72;
    localparam int R  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [N-1:0]  in_codeword;
    logic          out_ready;
    logic          cnt_clr;

    logic          in_ready,  in_ready4;
    logic          out_valid, out_valid4;
    logic [N-1:0]  out_codeword, out_codeword4;
    logic [R-1:0]  out_syndrome, out_syndrome4;
    logic          out_err,   out_err4;
    logic [CW-1:0] word_cnt,  err_cnt;
    logic [3:0]    word_cnt4, err_cnt4;

    always #5 clk = ~clk;

    scc_param_syndrome_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_codeword(in_codeword), .out_valid(out_valid), .out_ready(out_ready),
        .out_codeword(out_codeword), .out_syndrome(out_syndrome), .out_err(out_err),
        .cnt_clr(cnt_clr), .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    scc_param_syndrome_pipe #(.CW(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_codeword(in_codeword), .out_valid(out_valid4), .out_ready(out_ready),
        .out_codeword(out_codeword4), .out_syndrome(out_syndrome4), .out_err(out_err4),
        .cnt_clr(cnt_clr), .word_cnt(word_cnt4), .err_cnt(err_cnt4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Syndrome as sum of alpha^i over the set codeword bits.
    function automatic logic [7:0] ref_syn(input logic [71:0] cw);
        logic [7:0] s;
        logic [7:0] a;
        s = 8'h00;
        a = 8'h01;
        for (int i = 0; i < 72; i++) begin
            if (cw[i]) s = s ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1D) : (a << 1);
        end
        return s;
    endfunction

    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_cw;
    logic [7:0]   exp_syn;
    int           m_word = 0, m_err = 0, m_word4 = 0, m_err4 = 0;
    int           delivered = 0;
    int           out_seen = 0;
    bit           mon_on = 1'b0;
    bit           hold_pend = 1'b0;
    logic [N-1:0] hold_cw;
    logic [R-1:0] hold_syn;
    logic         hold_err;

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst) begin
                exp_q.delete();
                m_word = 0; m_err = 0; m_word4 = 0; m_err4 = 0;
                hold_pend = 1'b0;
            end else begin
                check_eq("word_cnt",  word_cnt,  m_word);
                check_eq("err_cnt",   err_cnt,   m_err);
                check_eq("word_cnt4", word_cnt4, m_word4);
                check_eq("err_cnt4",  err_cnt4,  m_err4);
                if (hold_pend) begin
                    check_eq("hold_cw",  out_codeword, hold_cw);
                    check_eq("hold_syn", out_syndrome, hold_syn);
                    check_eq("hold_err", out_err,      hold_err);
                end
                hold_pend = out_valid && !out_ready;
                hold_cw   = out_codeword;
                hold_syn  = out_syndrome;
                hold_err  = out_err;
                if (out_valid) out_seen++;
                if (out_valid && out_ready) begin
                    delivered++;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_out", 1, 0);
                        exp_syn = out_syndrome;
                    end else begin
                        exp_cw  = exp_q.pop_front();
                        exp_syn = ref_syn(exp_cw);
                        check_eq("out_codeword", out_codeword, exp_cw);
                        check_eq("out_syndrome", out_syndrome, exp_syn);
                        check_eq("out_err",      out_err,      exp_syn != 8'h00);
                    end
                    m_word  = (m_word  < 65535) ? m_word  + 1 : 65535;
                    m_word4 = (m_word4 < 15)    ? m_word4 + 1 : 15;
                    if (exp_syn != 8'h00) begin
                        m_err  = (m_err  < 65535) ? m_err  + 1 : 65535;
                        m_err4 = (m_err4 < 15)    ? m_err4 + 1 : 15;
                    end
                end
                if (cnt_clr) begin
                    m_word = 0; m_err = 0; m_word4 = 0; m_err4 = 0;
                end
                if (in_valid && in_ready) exp_q.push_back(in_codeword);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] cw);
        bit done;
        int budget;
        done   = 1'b0;
        budget = 0;
        in_valid    = 1'b1;
        in_codeword = cw;
        while (!done && budget < 100) begin
            @(negedge clk);
            done = in_ready;
            tick();
            budget++;
        end
        in_valid = 1'b0;
        if (!done) check_eq("send_timeout", 0, 1);
    endtask

    // Returns on the negedge at which out_valid is high.
    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else tick();
        end
        if (!seen) check_eq("out_timeout", 0, 1);
    endtask

    function automatic logic [N-1:0] one_hot(input int idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [N-1:0] dv [3];
    logic [R-1:0] ds [3];
    logic [N-1:0] sw [6];
    logic [95:0]  rnd;
    int           acc, base, seen0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_codeword = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        dv[0] = 72'h1;   ds[0] = 8'h01;
        dv[1] = 72'h80;  ds[1] = 8'h80;
        dv[2] = 72'h100; ds[2] = 8'h1D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid,    0);
        check_eq("rst_word_cnt",  word_cnt,     0);
        check_eq("rst_err_cnt",   err_cnt,      0);
        check_eq("rst_out_cw",    out_codeword, 0);
        check_eq("rst_out_syn",   out_syndrome, 0);
        check_eq("rst_out_err",   out_err,      0);
        tick();
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_rst", in_ready, 1);

        // Two-cycle latency for an all-zero word
        tick();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_codeword = '0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_t1_valid", out_valid, 0);
        tick();
        @(negedge clk);
        check_eq("lat_t2_valid", out_valid,    1);
        check_eq("lat_t2_syn",   out_syndrome, 8'h00);
        check_eq("lat_t2_err",   out_err,      0);

        // Single-bit vectors with known syndromes
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_word(dv[k]);
            wait_out();
            check_eq("vec_syn", out_syndrome, ds[k]);
            check_eq("vec_err", out_err,      1);
            tick();
        end
        @(negedge clk);
        check_eq("vec_word_cnt", word_cnt, 3);
        check_eq("vec_err_cnt",  err_cnt,  3);

        // Backpressure: six words against a stalled output
        tick();
        out_ready = 1'b0;
        base = delivered;
        for (int k = 0; k < 6; k++) begin
            rnd = {$urandom, $urandom, $urandom};
            sw[k] = rnd[N-1:0];
        end
        acc = 0;
        in_valid    = 1'b1;
        in_codeword = sw[0];
        repeat (5) begin
            @(negedge clk);
            if (in_ready) acc++;
            tick();
            in_codeword = sw[acc];
        end
        check_eq("stall_accepted", acc, 2);
        @(negedge clk);
        check_eq("stall_in_ready", in_ready, 0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && acc < 6; i++) begin
            @(negedge clk);
            if (in_ready) acc++;
            tick();
            if (acc < 6) in_codeword = sw[acc];
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && delivered < base + 6; i++) tick();
        check_eq("stall_delivered", delivered - base, 6);

        // Randomized traffic
        repeat (400) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rnd = {$urandom, $urandom, $urandom};
            in_codeword = rnd[N-1:0];
            if ($urandom_range(0, 3) == 0) in_codeword = one_hot($urandom_range(0, N - 1));
            if ($urandom_range(0, 7) == 0) in_codeword = '0;
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            tick();
        end
        in_valid  = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();

        // Counter saturation on the 4-bit instance
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int k = 0; k < 20; k++) send_word(one_hot($urandom_range(0, N - 1)));
        repeat (5) tick();
        @(negedge clk);
        check_eq("sat_word_cnt4", word_cnt4, 15);
        check_eq("sat_err_cnt4",  err_cnt4,  15);
        check_eq("sat_word_cnt",  word_cnt,  20);
        check_eq("sat_err_cnt",   err_cnt,   20);
        repeat (3) tick();
        @(negedge clk);
        check_eq("sat_hold_word4", word_cnt4, 15);
        check_eq("sat_hold_err4",  err_cnt4,  15);

        // Clear coinciding with an erroneous output handshake
        tick();
        out_ready = 1'b0;
        send_word(one_hot(5));
        wait_out();
        tick();
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check_eq("clr_word_cnt", word_cnt, 0);
        check_eq("clr_err_cnt",  err_cnt,  0);

        // Reset with two words in flight
        tick();
        out_ready = 1'b0;
        send_word(one_hot(9));
        send_word(one_hot(17));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", out_valid, 0);
        tick();
        out_ready = 1'b1;
        seen0 = out_seen;
        repeat (6) tick();
        check_eq("flush_no_output", out_seen - seen0, 0);

        check_eq("drain_queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
